fetch_unit_ras: RTL and testbench
=================================

# fetch_unit_ras

Parametrised instruction-fetch stage that adds a return address stack (RAS) to the fetch path. The stage keeps the PC, drives the instruction-memory address, and classifies the fetched word as jump, call, return, or conditional branch. It takes jump, call and predicted-branch redirects in the same cycle, and predicts return targets from the RAS. It sits between instruction memory and decode, receives branch-resolution results from execute, and checkpoints RAS state so a mispredict flush repairs the stack exactly.

## Interface
- PC_W, 16, PC width in words; legal 8..16, because the link immediate is 16 bits.
- RAS_DEPTH, 8, RAS entries; power of two, 2..64.
- R_RET, 8'd253, link register index written by the synthesised call instruction.

- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_addr  out  PC_W  address presented to instruction memory (next PC).
- imem_instr  in  32  instruction at the current PC, valid every cycle.
- pred_pc  out  PC_W  current PC, sent to the external branch predictor.
- pred_en  out  1  current word is a conditional branch.
- pred_taken  in  1  predictor verdict, combinational.
- br_en  in  1  branch-resolution result valid.
- br_miss  in  1  mispredict; flush and redirect.
- br_target  in  PC_W  correct PC after a mispredict.
- br_ckpt  in  RAS_CKPT_W  RAS checkpoint carried with the mispredicted instruction.
- out_en  out  1  decode slot valid.
- out_reject  in  1  decode stall (back-pressure).
- out_instr  out  32  instruction, or the synthesised call-link word.
- out_pc  out  PC_W  PC of out_instr.
- out_approx  out  1  fetch redirected on a prediction (branch or return).
- out_pred_target  out  PC_W  predicted target; execute compares against it.
- out_ckpt  out  RAS_CKPT_W  RAS state before this instruction's push or pop.

## Operation
- Decode of imem_instr:
  - JUMP: bits[31:29]=3'b111 and bit27=1. Target = pc + instr[23:8], modulo 2^PC_W.
  - CALL: a JUMP with bit24=1.
  - RET: instr[31:24]=8'hF4.
  - BRANCH: bit31=1 and bit30=0. Target = pc + sign-extended instr[26:16].
- Next-PC priority: flush > stall > JUMP/CALL > RET with a non-empty RAS > BRANCH with pred_taken > pc+1.
- A plain JUMP is consumed at fetch: out_en=0 for that word.
- CALL:
  - Emits {8'h1C, zero-extended (pc+1), R_RET} to decode, with out_en=1.
  - Pushes pc+1 onto the RAS.
- RET with a non-empty RAS:
  - Pops the top entry; next PC is the popped value.
  - out_approx=1 and out_pred_target is the popped value.
- RET with an empty RAS:
  - Falls through to pc+1, with out_approx=0 and out_pred_target=pc+1.
- BRANCH: out_approx=pred_taken; out_pred_target is the taken target or pc+1 accordingly.
- RAS storage:
  - Circular buffer with top pointer tp (log2 RAS_DEPTH bits) and occupancy count cnt (0..RAS_DEPTH).
  - A push at full wraps and overwrites the oldest entry; cnt saturates at RAS_DEPTH.
  - A pop decrements both tp and cnt.
- RAS checkpoint: out_ckpt = {cnt, tp}, sampled before this instruction's update. RAS_CKPT_W = log2(RAS_DEPTH) + log2(RAS_DEPTH+1).
- Flush (br_en & br_miss):
  - pc <= br_target and {cnt, tp} <= br_ckpt.
  - No push or pop happens that cycle; entry contents are not restored.
- Stall (out_reject): pc, tp and cnt are held; outputs stay stable.

## Timing
- Reset values:
  - pc=0, tp=0, cnt=0.
  - out_en=0 while reset is high; imem_addr=0.
  - RAS entries are undefined after reset.
- Fetch-to-redirect: zero bubbles for JUMP, CALL, RET and predicted-taken BRANCH. Next PC is combinational from imem_instr and is registered at the next edge.
- Flush: out_en=0 in the flush cycle. The instruction at br_target appears one cycle later.
- RAS push/pop commits at the rising edge only when out_en=1 and out_reject=0, or for a plain JUMP when there is no stall.
- Flush arriving during a stall: the flush wins, the stall is ignored.
- Reset deasserted mid-stream: the first fetch is from address 0 on the next edge.

## Configuration
- FETCH_RAS_EN defined: RAS present as described.
- FETCH_RAS_EN undefined:
  - No RAS storage; RET behaves as the empty-RAS case.
  - CALL still emits the link word but pushes nothing.
  - out_ckpt=0 and br_ckpt is ignored.

## Structure
- Shared package fetch_pkg holds:
  - Opcode constants OP_RET=8'hF4 and OP_MOVL=8'h1C, plus R_RET.
  - The checkpoint typedef.
  - The decode-class enum: NONE, JUMP, CALL, RET, BRANCH.
- One sub-module, fetch_ras: push, pop, checkpoint restore, plus top and empty outputs.

## Test plan
- Reset asserted for 3 cycles, then released: imem_addr=0 and out_en=0 during reset; out_pc=0 on the first valid cycle.
- CALL at pc=0x10 with offset 0x20:
  - out_instr={1C, 0x0011, FD}; next pc=0x30; cnt=1.
  - RET at 0x30 then redirects to 0x11 with out_approx=1.
- RAS_DEPTH=4 with 5 nested CALLs, then 5 RETs:
  - The first 4 RETs return the newest-first addresses.
  - The 5th RET falls through to pc+1 with out_approx=0.
- CALL accepted, then flush with br_ckpt={cnt=0, tp=0}: cnt=0 afterwards, and a subsequent RET falls through.
- out_reject held 3 cycles over a RET: tp, cnt and out_* are stable, and exactly one pop occurs on release.
- Build without FETCH_RAS_EN: CALL/RET pair at 0x10→0x30, RET yields pc 0x31, out_ckpt=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants, decode classes and the default-depth RAS checkpoint layout.
package fetch_pkg;

  localparam logic [7:0] OP_RET  = 8'hF4;
  localparam logic [7:0] OP_MOVL = 8'h1C;
  localparam logic [7:0] R_RET   = 8'd253;

  localparam int unsigned RAS_DEPTH_DEF = 8;
  localparam int unsigned CKPT_TP_W     = $clog2(RAS_DEPTH_DEF);
  localparam int unsigned CKPT_CNT_W    = $clog2(RAS_DEPTH_DEF + 1);

  typedef struct packed {
    logic [CKPT_CNT_W-1:0] cnt;
    logic [CKPT_TP_W-1:0]  tp;
  } ras_ckpt_t;

  typedef enum logic [2:0] {NONE, JUMP, CALL, RET, BRANCH} fetch_cls_e;

endpackage

// File: rtl/fetch_ras.sv
// Circular return address stack with {cnt, tp} checkpoint and restore.
// Only present when FETCH_RAS_EN is defined.
`ifdef FETCH_RAS_EN
module fetch_ras #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 16,
  localparam int unsigned TP_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    restore,
  input  logic [PC_W-1:0]         push_data,
  input  logic [CNT_W+TP_W-1:0]   restore_ckpt,
  output logic [PC_W-1:0]         top,
  output logic                    empty,
  output logic [CNT_W+TP_W-1:0]   ckpt
);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [TP_W-1:0]  tp;
  logic [CNT_W-1:0] cnt;

  // tp points at the next free slot; a push at full overwrites the oldest entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tp  <= '0;
      cnt <= '0;
    end else if (restore) begin
      {cnt, tp} <= restore_ckpt;
    end else if (push) begin
      tp <= tp + TP_W'(1);
      if (cnt != CNT_W'(DEPTH)) cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      tp  <= tp - TP_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !restore) mem[tp] <= push_data;
  end

  assign top   = mem[tp - TP_W'(1)];
  assign empty = (cnt == '0);
  assign ckpt  = {cnt, tp};

endmodule
`endif

// File: rtl/fetch_unit_ras.sv
// Fetch stage: PC, instruction classification, zero-bubble redirects and RAS return prediction.
// Define FETCH_RAS_EN to include the return address stack; otherwise RET always falls through.
module fetch_unit_ras #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 8,
  parameter logic [7:0]  R_RET     = fetch_pkg::R_RET,
  localparam int unsigned TP_W       = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W      = $clog2(RAS_DEPTH + 1),
  localparam int unsigned RAS_CKPT_W = TP_W + CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [31:0]           imem_instr,
  output logic [PC_W-1:0]       pred_pc,
  output logic                  pred_en,
  input  logic                  pred_taken,
  input  logic                  br_en,
  input  logic                  br_miss,
  input  logic [PC_W-1:0]       br_target,
  input  logic [RAS_CKPT_W-1:0] br_ckpt,
  output logic                  out_en,
  input  logic                  out_reject,
  output logic [31:0]           out_instr,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_approx,
  output logic [PC_W-1:0]       out_pred_target,
  output logic [RAS_CKPT_W-1:0] out_ckpt
);
  import fetch_pkg::*;

  logic [PC_W-1:0] pc, pc_inc, jump_target, branch_target, next_pc, ras_top;
  logic [15:0]     br_off;
  logic            flush, ras_empty, ret_hit, br_taken;
  fetch_cls_e      cls;

  assign flush         = br_en & br_miss;
  assign pc_inc        = pc + PC_W'(1);
  assign jump_target   = pc + PC_W'(imem_instr[23:8]);
  assign br_off        = {{5{imem_instr[26]}}, imem_instr[26:16]};
  assign branch_target = pc + PC_W'(br_off);

  always_comb begin
    cls = NONE;
    if (imem_instr[31:29] == 3'b111 && imem_instr[27]) cls = imem_instr[24] ? CALL : JUMP;
    else if (imem_instr[31:24] == OP_RET)              cls = RET;
    else if (imem_instr[31:30] == 2'b10)               cls = BRANCH;
  end

  assign ret_hit  = (cls == RET) && !ras_empty;
  assign br_taken = (cls == BRANCH) && pred_taken;

  always_comb begin
    next_pc = pc_inc;
    if (flush)                          next_pc = br_target;
    else if (out_reject)                next_pc = pc;
    else if (cls == JUMP || cls == CALL) next_pc = jump_target;
    else if (ret_hit)                   next_pc = ras_top;
    else if (br_taken)                  next_pc = branch_target;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= next_pc;
  end

  assign imem_addr       = reset ? '0 : next_pc;
  assign pred_pc         = pc;
  assign pred_en         = (cls == BRANCH);
  assign out_pc          = pc;
  // A plain jump is fully handled here and never reaches decode
  assign out_en          = !reset && !flush && (cls != JUMP);
  assign out_instr       = (cls == CALL) ? {OP_MOVL, 16'(pc_inc), R_RET} : imem_instr;
  assign out_approx      = ret_hit | br_taken;
  assign out_pred_target = ret_hit ? ras_top : (br_taken ? branch_target : pc_inc);

`ifdef FETCH_RAS_EN
  logic commit, ras_push, ras_pop;

  assign commit   = !reset && !flush && !out_reject;
  assign ras_push = commit && (cls == CALL);
  assign ras_pop  = commit && ret_hit;

  fetch_ras #(
    .DEPTH (RAS_DEPTH),
    .PC_W  (PC_W)
  ) u_ras (
    .clock        (clock),
    .reset        (reset),
    .push         (ras_push),
    .pop          (ras_pop),
    .restore      (flush),
    .push_data    (pc_inc),
    .restore_ckpt (br_ckpt),
    .top          (ras_top),
    .empty        (ras_empty),
    .ckpt         (out_ckpt)
  );
`else
  logic unused_ckpt;

  assign unused_ckpt = ^br_ckpt;
  assign ras_top     = '0;
  assign ras_empty   = 1'b1;
  assign out_ckpt    = '0;
`endif

endmodule

// File: tb/tb_fetch_unit_ras.sv
// Vector/scoreboard bench for fetch_unit_ras (RAS_DEPTH=4); follows FETCH_RAS_EN like the RTL.
module tb_fetch_unit_ras;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clock, reset;
  logic [15:0] imem_addr, pred_pc, br_target, out_pc, out_pred_target;
  logic [31:0] imem_instr, out_instr;
  logic        pred_en, pred_taken, br_en, br_miss, out_en, out_reject, out_approx;
  logic [4:0]  br_ckpt, out_ckpt;

  fetch_unit_ras #(.PC_W(16), .RAS_DEPTH(DEPTH), .R_RET(8'd253)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pred_pc(pred_pc), .pred_en(pred_en), .pred_taken(pred_taken), .br_en(br_en),
    .br_miss(br_miss), .br_target(br_target), .br_ckpt(br_ckpt), .out_en(out_en),
    .out_reject(out_reject), .out_instr(out_instr), .out_pc(out_pc), .out_approx(out_approx),
    .out_pred_target(out_pred_target), .out_ckpt(out_ckpt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic        taken, reject, ben, bmiss;
    logic [15:0] target;
    logic [4:0]  ckpt;
    logic        chk;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    logic        en, pred_en, approx, push, pop;
    logic [31:0] instr;
    logic [15:0] pc, addr, tgt;
    logic [4:0]  ckpt;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RTN = 32'hF400_0000;

  int n_vec = 0, n_err = 0;
  vec_t vt[$];
  exp_t sb[$];

  logic [15:0] m_pc;
  int          m_tp, m_cnt;
  logic [15:0] m_mem [DEPTH];

  function automatic logic [31:0] f_jump(logic [15:0] off); return {8'hE8, off, 8'h00}; endfunction
  function automatic logic [31:0] f_call(logic [15:0] off); return {8'hE9, off, 8'h00}; endfunction
  function automatic logic [31:0] f_br(logic [10:0] off);   return {5'b10000, off, 16'h0}; endfunction

  function automatic vec_t mk(logic [31:0] instr, logic taken, logic reject, logic ben, logic bmiss,
                              logic [15:0] target, logic [4:0] ckpt, logic chk, logic [15:0] exp_addr);
    vec_t v;
    v.instr = instr; v.taken = taken; v.reject = reject; v.ben = ben; v.bmiss = bmiss;
    v.target = target; v.ckpt = ckpt; v.chk = chk; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one fetch cycle, from the model state before the edge
  function automatic exp_t model_eval(vec_t v);
    exp_t e;
    logic [15:0] pc1, top, btgt;
    logic jmp, call, ret, br, flush, hit, tk;
    pc1   = m_pc + 16'd1;
    jmp   = (v.instr[31:29] == 3'b111) && v.instr[27];
    call  = jmp && v.instr[24];
    ret   = (v.instr[31:24] == 8'hF4);
    br    = (v.instr[31:30] == 2'b10);
    flush = v.ben && v.bmiss;
    top   = m_mem[(m_tp + DEPTH - 1) % DEPTH];
    hit   = ret && RAS_ON && (m_cnt > 0);
    tk    = br && v.taken;
    btgt  = m_pc + {{5{v.instr[26]}}, v.instr[26:16]};
    e.en      = !flush && !(jmp && !call);
    e.pred_en = br;
    e.instr   = call ? {8'h1C, pc1, 8'hFD} : v.instr;
    e.pc      = m_pc;
    e.approx  = hit || tk;
    e.tgt     = hit ? top : (tk ? btgt : pc1);
    if (flush)         e.addr = v.target;
    else if (v.reject) e.addr = m_pc;
    else if (jmp)      e.addr = m_pc + v.instr[23:8];
    else if (hit)      e.addr = top;
    else if (tk)       e.addr = btgt;
    else               e.addr = pc1;
    e.ckpt = RAS_ON ? {3'(m_cnt), 2'(m_tp)} : 5'd0;
    e.push = RAS_ON && call && !flush && !v.reject;
    e.pop  = hit && !flush && !v.reject;
    return e;
  endfunction

  task automatic model_commit(vec_t v, exp_t e);
    if (v.ben && v.bmiss) begin
      m_pc = v.target;
      if (RAS_ON) begin
        m_cnt = int'(v.ckpt[4:2]);
        m_tp  = int'(v.ckpt[1:0]);
      end
    end else if (!v.reject) begin
      if (e.push) begin
        m_mem[m_tp] = m_pc + 16'd1;
        m_tp = (m_tp + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
      end
      if (e.pop) begin
        m_tp = (m_tp + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
      m_pc = e.addr;
    end
  endtask

  task automatic drive(vec_t v);
    imem_instr = v.instr; pred_taken = v.taken; out_reject = v.reject;
    br_en = v.ben; br_miss = v.bmiss; br_target = v.target; br_ckpt = v.ckpt;
  endtask

  initial begin
    logic [15:0] p;
    exp_t e;
    p = RAS_ON ? 16'h0011 : 16'h0031;

    vt.push_back(mk(NOP,              0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 0
    vt.push_back(mk(f_jump(16'h000F), 0, 0, 0, 0, 16'h0, 5'd0, 1, 16'h0010));  // 1
    vt.push_back(mk(f_call(16'h0020), 0, 0, 0, 0, 16'h0, 5'd0, 1, 16'h0030));  // 2
    vt.push_back(mk(RTN,              0, 0, 0, 0, 16'h0, 5'd0, 1, p));         // 3
    for (int k = 0; k < 5; k++) vt.push_back(mk(f_call(16'h0010), 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));
    vt.push_back(mk(RTN, 0, 0, 0, 0, 16'h0, 5'd0, 1, RAS_ON ? p + 16'h41 : p + 16'h51)); // 9
    for (int k = 0; k < 3; k++) vt.push_back(mk(RTN, 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));
    vt.push_back(mk(RTN, 0, 0, 0, 0, 16'h0, 5'd0, 1, RAS_ON ? p + 16'h12 : p + 16'h55)); // 13
    vt.push_back(mk(f_br(11'h005),    1, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 14
    vt.push_back(mk(f_br(11'h7FD),    1, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 15
    vt.push_back(mk(f_br(11'h100),    0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 16
    vt.push_back(mk(f_call(16'h0040), 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 17
    for (int k = 0; k < 3; k++) vt.push_back(mk(RTN, 0, 1, 0, 0, 16'h0, 5'd0, 0, 16'h0));
    vt.push_back(mk(RTN,              0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 21
    vt.push_back(mk(NOP,              0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 22
    vt.push_back(mk(f_call(16'h0008), 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 23
    vt.push_back(mk(NOP,              0, 0, 1, 1, 16'h0200, 5'd0, 1, 16'h0200)); // 24
    vt.push_back(mk(RTN,              0, 0, 0, 0, 16'h0, 5'd0, 1, 16'h0201));  // 25
    vt.push_back(mk(NOP,              0, 1, 1, 1, 16'h0300, {3'd2, 2'd3}, 1, 16'h0300)); // 26
    vt.push_back(mk(RTN,              0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 27
    vt.push_back(mk(NOP,              0, 0, 1, 0, 16'h0777, 5'd0, 0, 16'h0));  // 28
    vt.push_back(mk(f_jump(16'h0100), 0, 1, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 29
    vt.push_back(mk(f_jump(16'h0100), 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 30
    vt.push_back(mk(f_br(11'h400),    1, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 31
    vt.push_back(mk(f_jump(16'hFFFF), 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 32
    vt.push_back(mk(NOP,              0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));     // 33

    // Reset held for three cycles
    reset = 1'b1;
    drive(mk(NOP, 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));
    m_pc = 16'h0; m_tp = 0; m_cnt = 0;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 16'h0;
    repeat (3) begin
      @(negedge clock); #2;
      check("reset_imem_addr", imem_addr, 32'h0);
      check("reset_out_en", out_en, 32'h0);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clock);
      drive(vt[i]);
      sb.push_back(model_eval(vt[i]));
      #2;
      e = sb.pop_front();
      check($sformatf("v%0d_out_en", i), out_en, e.en);
      check($sformatf("v%0d_pred_en", i), pred_en, e.pred_en);
      check($sformatf("v%0d_out_pc", i), out_pc, e.pc);
      check($sformatf("v%0d_pred_pc", i), pred_pc, e.pc);
      check($sformatf("v%0d_imem_addr", i), imem_addr, e.addr);
      check($sformatf("v%0d_out_ckpt", i), out_ckpt, e.ckpt);
      if (e.en) begin
        check($sformatf("v%0d_out_instr", i), out_instr, e.instr);
        check($sformatf("v%0d_out_approx", i), out_approx, e.approx);
        check($sformatf("v%0d_pred_target", i), out_pred_target, e.tgt);
      end
      if (vt[i].chk) check($sformatf("v%0d_hand_addr", i), imem_addr, vt[i].exp_addr);
      if (i == 2) check("call_link_word", out_instr, 32'h1C00_11FD);
      if (i == 3) begin
        check("ret_approx", out_approx, RAS_ON);
        check("ckpt_after_call", out_ckpt, RAS_ON ? 5'b001_01 : 5'd0);
      end
      @(posedge clock);
      model_commit(vt[i], e);
    end

    // Reset asserted mid-stream, then released
    @(negedge clock);
    drive(mk(NOP, 0, 0, 0, 0, 16'h0, 5'd0, 0, 16'h0));
    reset = 1'b1;
    #1;
    check("midreset_out_en", out_en, 32'h0);
    check("midreset_imem_addr", imem_addr, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_out_pc", out_pc, 32'h0);
    check("post_reset_out_en", out_en, 32'h1);
    check("post_reset_imem_addr", imem_addr, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
